fetch_unit: RTL and testbench

Program-counter and fetch sequencer for the 9-bit core. It drives the instruction ROM address and consumes the decoder's branch_en and flag_write, plus the ALU compare result. It holds the architectural compare flag and an 8-entry branch-target table. A small run-control state machine (IDLE/RUN/HALT) sequences program start and completion.

---
 rtl/fetch_unit_if.sv | 32 +++
 rtl/fetch_unit.sv | 113 +++++++++++
 tb/tb_fetch_unit.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Bus between the decoder/ALU side and the fetch unit: control inputs,
// target-table write port, and the PC/flag/run-status outputs.
interface fetch_unit_if #(
  parameter int PC_W = 10
);
  logic            Start;
  logic            Branch_en;
  logic            Branch_pol;
  logic [2:0]      Target_idx;
  logic            Flag_write;
  logic            Flag_in;
  logic            Halt;
  logic            Lut_we;
  logic [2:0]      Lut_waddr;
  logic [PC_W-1:0] Lut_wdata;
  logic [PC_W-1:0] PC;
  logic            Flag;
  logic            Running;
  logic            Done;

  modport master (
    output Start, Branch_en, Branch_pol, Target_idx, Flag_write, Flag_in,
           Halt, Lut_we, Lut_waddr, Lut_wdata,
    input  PC, Flag, Running, Done
  );

  modport slave (
    input  Start, Branch_en, Branch_pol, Target_idx, Flag_write, Flag_in,
           Halt, Lut_we, Lut_waddr, Lut_wdata,
    output PC, Flag, Running, Done
  );
endinterface

// File: rtl/fetch_unit.sv
// PC / fetch sequencer with compare flag, 8-entry branch-target table and IDLE/RUN/HALT control.
// Define FETCH_REL_BRANCH_EN to make table entries PC-relative two's-complement offsets.
module fetch_unit #(
  parameter int              PC_W       = 10,
  parameter logic [PC_W-1:0] START_ADDR = '0,
  parameter logic [PC_W-1:0] PROG_END   = {PC_W{1'b1}}
) (
  input  logic         Clk,
  input  logic         Reset_n,
  fetch_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            flag_q, flag_d;
  logic            running_q, running_d;
  logic            done_q, done_d;

  logic [PC_W-1:0] lut_q [8];
  logic [7:0]      lut_wen;
  logic [PC_W-1:0] lut_entry;
  logic [PC_W-1:0] branch_target;
  logic            branch_taken;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lut_wen
      assign lut_wen[gi] = bus.Lut_we && (bus.Lut_waddr == 3'(gi));
    end
  endgenerate

  // Table needs async clear, so it lives in flops rather than block RAM.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < 8; i++) lut_q[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (lut_wen[i]) lut_q[i] <= bus.Lut_wdata;
      end
    end
  end

  // Reads the pre-edge entry, so a same-cycle write to this index is not seen.
  assign lut_entry = lut_q[bus.Target_idx];

`ifdef FETCH_REL_BRANCH_EN
  assign branch_target = pc_q + lut_entry;
`else
  assign branch_target = lut_entry;
`endif

  assign branch_taken = bus.Branch_en && (flag_q == bus.Branch_pol);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flag_d  = flag_q;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (bus.Start) begin
          pc_d    = START_ADDR;
          flag_d  = 1'b0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.Flag_write) flag_d = bus.Flag_in;
        if (bus.Halt) begin
          state_d = ST_HALT;
        end else if (branch_taken) begin
          pc_d = branch_target;
        end else if (pc_q == PROG_END) begin
          state_d = ST_HALT;
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    running_d = (state_d == ST_RUN);
    done_d    = (state_d == ST_HALT);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      flag_q    <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      flag_q    <= flag_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign bus.PC      = pc_q;
  assign bus.Flag    = flag_q;
  assign bus.Running = running_q;
  assign bus.Done    = done_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit (PROG_END overridden to 7); expected PCs are hand-derived,
// with the branch target rule switched by FETCH_REL_BRANCH_EN.
module tb_fetch_unit;
  localparam int PC_W = 10;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  logic [PC_W-1:0] pc_exp;

  fetch_unit_if #(.PC_W(PC_W)) bus ();

  fetch_unit #(
    .PC_W      (PC_W),
    .START_ADDR(10'd0),
    .PROG_END  (10'd7)
  ) dut (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .bus    (bus)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic check_state(input string tag, input logic [PC_W-1:0] pc, input logic flag,
                             input logic run, input logic done);
    check({tag, ".pc"},      32'(bus.PC),      32'(pc));
    check({tag, ".flag"},    32'(bus.Flag),    32'(flag));
    check({tag, ".running"}, 32'(bus.Running), 32'(run));
    check({tag, ".done"},    32'(bus.Done),    32'(done));
  endtask

  function automatic logic [PC_W-1:0] tgt(input logic [PC_W-1:0] pc, input logic [PC_W-1:0] entry);
`ifdef FETCH_REL_BRANCH_EN
    return pc + entry;
`else
    return entry;
`endif
  endfunction

  task automatic step;
    @(posedge Clk);
    #1;
  endtask

  task automatic clr;
    bus.Start      = 1'b0;
    bus.Branch_en  = 1'b0;
    bus.Branch_pol = 1'b0;
    bus.Target_idx = 3'd0;
    bus.Flag_write = 1'b0;
    bus.Flag_in    = 1'b0;
    bus.Halt       = 1'b0;
    bus.Lut_we     = 1'b0;
    bus.Lut_waddr  = 3'd0;
    bus.Lut_wdata  = '0;
  endtask

  task automatic lut_write(input logic [2:0] idx, input logic [PC_W-1:0] data);
    bus.Lut_we    = 1'b1;
    bus.Lut_waddr = idx;
    bus.Lut_wdata = data;
    step();
    clr();
  endtask

  task automatic branch(input logic pol, input logic [2:0] idx);
    bus.Branch_en  = 1'b1;
    bus.Branch_pol = pol;
    bus.Target_idx = idx;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    Reset_n = 1'b0;
    #12;
    check_state("reset", 10'd0, 1'b0, 1'b0, 1'b0);
    Reset_n = 1'b1;
    step();
    check_state("idle_hold", 10'd0, 1'b0, 1'b0, 1'b0);

    lut_write(3'd3, 10'd40);
    lut_write(3'd4, 10'd5);
    lut_write(3'd2, 10'd2);
    lut_write(3'd5, 10'd12);
    check_state("idle_lut", 10'd0, 1'b0, 1'b0, 1'b0);

    // Start and straight-line counting
    bus.Start = 1'b1; step(); clr();
    pc_exp = 10'd0;
    check_state("t1_start", pc_exp, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      step();
      pc_exp = pc_exp + 10'd1;
      check("t1_count.pc", 32'(bus.PC), 32'(pc_exp));
    end

    // Flag set, then taken / not-taken branches
    bus.Flag_write = 1'b1; bus.Flag_in = 1'b1; step(); clr();
    pc_exp = 10'd4;
    check_state("t2_flagset", pc_exp, 1'b1, 1'b1, 1'b0);
    branch(1'b1, 3'd3); step(); clr();
    pc_exp = tgt(pc_exp, 10'd40);
    check("t2_taken.pc", 32'(bus.PC), 32'(pc_exp));
    branch(1'b0, 3'd3); step(); clr();
    pc_exp = pc_exp + 10'd1;
    check("t2_nottaken.pc", 32'(bus.PC), 32'(pc_exp));

    // Same-cycle flag write does not steer the branch
    bus.Flag_write = 1'b1; bus.Flag_in = 1'b0; step(); clr();
    pc_exp = pc_exp + 10'd1;
    check_state("t3_flagclr", pc_exp, 1'b0, 1'b1, 1'b0);
    bus.Flag_write = 1'b1; bus.Flag_in = 1'b1; branch(1'b1, 3'd3); step(); clr();
    pc_exp = pc_exp + 10'd1;
    check_state("t3_preflag", pc_exp, 1'b1, 1'b1, 1'b0);

    bus.Start = 1'b1; step(); clr();
    pc_exp = pc_exp + 10'd1;
    check_state("run_start_ign", pc_exp, 1'b1, 1'b1, 1'b0);

    // Halt beats a taken branch; HALT ignores Flag_write; Start restarts
    branch(1'b1, 3'd4); step(); clr();
    pc_exp = tgt(pc_exp, 10'd5);
    check("t4_to5.pc", 32'(bus.PC), 32'(pc_exp));
    bus.Halt = 1'b1; branch(1'b1, 3'd3); step(); clr();
    check_state("t4_halt", pc_exp, 1'b1, 1'b0, 1'b1);
    bus.Flag_write = 1'b1; bus.Flag_in = 1'b0; step(); clr();
    check_state("t4_hold", pc_exp, 1'b1, 1'b0, 1'b1);
    bus.Start = 1'b1; step(); clr();
    pc_exp = 10'd0;
    check_state("t4_restart", pc_exp, 1'b0, 1'b1, 1'b0);

    // PROG_END = 7
    repeat (7) step();
    pc_exp = 10'd7;
    check_state("t5_at_end", pc_exp, 1'b0, 1'b1, 1'b0);
    step();
    check_state("t5_halt", pc_exp, 1'b0, 1'b0, 1'b1);
    step();
    check_state("t5_halt_hold", pc_exp, 1'b0, 1'b0, 1'b1);
    bus.Start = 1'b1; step(); clr();
    repeat (7) step();
    check_state("t5_again_end", 10'd7, 1'b0, 1'b1, 1'b0);
    branch(1'b0, 3'd2); step(); clr();
    pc_exp = tgt(10'd7, 10'd2);
    check_state("t5_branch_end", pc_exp, 1'b0, 1'b1, 1'b0);

    // Same-edge table write to the branch index: old entry used
    bus.Lut_we = 1'b1; bus.Lut_waddr = 3'd2; bus.Lut_wdata = 10'd30;
    branch(1'b0, 3'd2); step(); clr();
    pc_exp = tgt(pc_exp, 10'd2);
    check("lut_old.pc", 32'(bus.PC), 32'(pc_exp));
    branch(1'b0, 3'd2); step(); clr();
    pc_exp = tgt(pc_exp, 10'd30);
    check("lut_new.pc", 32'(bus.PC), 32'(pc_exp));

    bus.Flag_write = 1'b1; bus.Flag_in = 1'b1; branch(1'b0, 3'd5); step(); clr();
    pc_exp = tgt(pc_exp, 10'd12);
    check_state("t6_pre", pc_exp, 1'b1, 1'b1, 1'b0);

    // Async reset between edges
    #3 Reset_n = 1'b0;
    #1 check_state("t6_async_rst", 10'd0, 1'b0, 1'b0, 1'b0);
    #2 Reset_n = 1'b1;
    step();
    check_state("t6_idle", 10'd0, 1'b0, 1'b0, 1'b0);

    lut_write(3'd6, 10'd20);
    lut_write(3'd1, 10'h3FC);
    bus.Start = 1'b1; step(); clr();
    branch(1'b0, 3'd3); step(); clr();
    check("lut_cleared.pc", 32'(bus.PC), 32'(tgt(10'd0, 10'd0)));
    branch(1'b0, 3'd6); step(); clr();
    pc_exp = tgt(10'd0, 10'd20);
    check("t6_to20.pc", 32'(bus.PC), 32'(pc_exp));
    branch(1'b0, 3'd1); step(); clr();
    pc_exp = tgt(pc_exp, 10'h3FC);
    check_state("t6_rel", pc_exp, 1'b0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
